regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
Debug read engine that sits beside the CPU register file and drives one of its read ports. On a start command it walks a register-address range, one register at a time, and captures each 32-bit value. It streams each (address, data) pair out over a valid/ready handshake and keeps a running checksum. It is used by the debug/test harness to dump architectural state without halting the write path.

Parameters:
AW, 5, register address width
DW, 32, register data width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
start  input  1  one-cycle request to begin a dump; sampled only in IDLE
first_addr  input  AW  first register address; latched on accepted start
last_addr  input  AW  last register address, inclusive; latched on accepted start
abort  input  1  cancel the dump in progress
rd_en  output  1  engine owns the register-file read port this cycle (port mux select)
rd_addr  output  AW  register-file read address, registered
rd_data  input  DW  register-file read data, combinational from rd_addr; address 0 reads 0
out_valid  output  1  out_addr/out_data/out_last valid
out_ready  input  1  consumer accepts the word
out_addr  output  AW  address of the streamed word
out_data  output  DW  captured register value
out_last  output  1  the streamed word is the final one of the dump
busy  output  1  dump in progress (FETCH or SEND)
done  output  1  one-cycle pulse after the last word is accepted
checksum  output  DW  sum mod 2^DW of all accepted out_data words in the current or most recent dump

Behaviour:
- Reset (reset==0 at posedge): state=IDLE. rd_en, rd_addr, out_valid, out_addr, out_data, out_last, busy, done and checksum are all 0. Reset mid-dump discards all progress.
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start=1 and abort=0: latch first_addr into cur and last_addr into end, clear checksum, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH (1 cycle):
  - rd_en=1, rd_addr=cur, busy=1.
  - At posedge: out_data<=rd_data, out_addr<=cur, out_last<=(cur==end), then go to SEND.
- SEND:
  - out_valid=1, busy=1, rd_en=0.
  - out_addr, out_data and out_last are held stable while out_ready=0.
  - Handshake (out_valid & out_ready):
    - checksum <= checksum + out_data, truncated to DW.
    - If out_last: go to DONE.
    - Else: cur <= cur+1 mod 2^AW, go to FETCH.
- DONE (1 cycle): done=1, busy=0, out_valid=0, then go to IDLE.
- Latency: start accepted at edge N gives FETCH in cycle N+1 and out_valid in cycle N+2.
  - Minimum 2 cycles per word.
  - With out_ready tied high, an n-word dump takes 2n cycles from FETCH entry, plus 1 DONE cycle.
- Range and wrap:
  - Word count = ((last_addr - first_addr) mod 2^AW) + 1.
  - first_addr > last_addr wraps through 31 to 0.
  - first_addr == last_addr dumps exactly one word, with out_last=1.
  - A full dump is first=0, last=31 (32 words), or any first with last=first-1 mod 32.
- Abort:
  - abort=1 in FETCH or SEND: go to IDLE at the next edge.
  - out_valid, rd_en and busy drop at that edge. No done pulse.
  - checksum holds the sum of the words accepted before the abort.
  - If abort and a handshake occur in the same cycle, abort wins. The word is counted in checksum, but there is no further FETCH and no done.
  - abort in IDLE or DONE has no effect beyond blocking start in IDLE.
- start while busy or in DONE: ignored. Latched range is unchanged.
- Register file writes during a dump are not blocked. Each word reflects the register value sampled in its FETCH cycle.
- out_valid is never deasserted without a handshake, except by abort or reset.

Test Plan:
- Preload r1..r3 = 0x11111111, 0x22222222, 0x33333333; start with first=1, last=3, out_ready=1 -> three words (1,0x11111111), (2,0x22222222), (3,0x33333333,last=1) on cycles N+2, N+4, N+6; done pulses at N+7; checksum=0x66666666.
- Wrap: first=30, last=1, r30=5, r31=6, r1=7 -> addresses 30,31,0,1 with data 5,6,0,7; out_last only on address 1; checksum=18.
- Backpressure: first=last=4, r4=0xDEADBEEF, out_ready low for 5 cycles then high -> out_valid stays high with out_data=0xDEADBEEF stable all 5 cycles; exactly one handshake; done follows on the next cycle.
- Abort: dump 0..31 with out_ready=1, abort asserted during the SEND of address 2 -> next cycle busy=0, out_valid=0, no done; checksum=r0+r1+r2; a new start is accepted afterwards.
- start re-asserted while busy with a different range -> ignored; the original range completes unchanged.
- Reset low asserted mid-SEND -> at the next edge all outputs are 0 and state is IDLE; after release, a fresh start=1 with first=last=0 yields one word (0,0) with out_last=1.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Debug engine that walks a register-file address range through one read port,
// streams (address, data) pairs over valid/ready and keeps a running checksum.
module regfile_dump_reader #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] first_addr,
    input  logic [AW-1:0] last_addr,
    input  logic          abort,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t        state, stateNext;
    logic [AW-1:0] curAddr, endAddr;
    logic          handshake;

    assign handshake = out_valid & out_ready;
    assign rd_addr   = curAddr;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        rd_en     = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) stateNext = FETCH;
            end
            FETCH: begin
                rd_en     = 1'b1;
                busy      = 1'b1;
                stateNext = abort ? IDLE : SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                // abort outranks a simultaneous handshake for the next state
                if (abort)          stateNext = IDLE;
                else if (out_ready) stateNext = out_last ? DONE : FETCH;
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            curAddr  <= '0;
            endAddr  <= '0;
            out_addr <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            checksum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        curAddr  <= first_addr;
                        endAddr  <= last_addr;
                        checksum <= '0;
                    end
                end
                FETCH: begin
                    if (!abort) begin
                        out_data <= rd_data;
                        out_addr <= curAddr;
                        out_last <= (curAddr == endAddr);
                    end
                end
                SEND: begin
                    // an accepted word is always counted, even when aborted
                    if (handshake) begin
                        checksum <= checksum + out_data;
                        if (!out_last && !abort) curAddr <= curAddr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: table of dump ranges plus hand sequences,
// checked against a queue-based model of the expected word stream.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  first_addr, last_addr;
    logic        abort;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid, out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last, busy, done;
    logic [31:0] checksum;

    logic [31:0] regs [32];
    int nCmp = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    assign rd_data = (rd_addr == 5'd0) ? 32'd0 : regs[rd_addr];

    regfile_dump_reader #(.AW(5), .DW(32)) dut (
        .clk(clk), .reset(reset), .start(start), .first_addr(first_addr),
        .last_addr(last_addr), .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .checksum(checksum)
    );

    typedef struct {
        logic [4:0]  f;
        logic [4:0]  l;
        int          readyPct;
        int          abortAddr;
        bit          noisy;
        bit          hasSum;
        logic [31:0] expSum;
    } vec_t;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic runDump(input logic [4:0] f, input logic [4:0] l, input int readyPct,
                           input int abortAddr, input bit noisy);
        logic [4:0]  qa[$];
        logic [31:0] qd[$];
        logic [31:0] sum;
        int n, cyc;
        bit aborted;
        logic [4:0] a;
        n = int'(5'(l - f)) + 1;
        for (int i = 0; i < n; i++) begin
            a = 5'(int'(f) + i);
            qa.push_back(a);
            qd.push_back(a == 5'd0 ? 32'd0 : regs[a]);
        end
        sum = 0;
        start = 1'b1; first_addr = f; last_addr = l; abort = 1'b0;
        step();
        start = 1'b0;
        chk("fetch_busy", busy, 1);
        chk("fetch_rd_en", rd_en, 1);
        chk("fetch_rd_addr", rd_addr, f);
        aborted = 0;
        cyc = 0;
        while (qa.size() > 0 && !aborted && cyc < 2000) begin
            out_ready = ($urandom_range(99) < readyPct);
            if (noisy) begin
                start = 1'($urandom_range(1));
                first_addr = 5'($urandom);
                last_addr = 5'($urandom);
            end
            if (readyPct >= 100) chk("valid_phase", out_valid, (cyc % 2) == 1);
            if (out_valid) begin
                chk("out_addr", out_addr, qa[0]);
                chk("out_data", out_data, qd[0]);
                chk("out_last", out_last, qa.size() == 1);
                if (abortAddr >= 0 && int'(qa[0]) == abortAddr) begin
                    abort = 1'b1;
                    aborted = 1;
                end
                if (out_ready) begin
                    sum += qd[0];
                    void'(qa.pop_front());
                    void'(qd.pop_front());
                end
            end
            step();
            cyc++;
        end
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        chk("dump_in_budget", cyc < 2000, 1);
        if (aborted) begin
            chk("abort_busy", busy, 0);
            chk("abort_valid", out_valid, 0);
            chk("abort_rd_en", rd_en, 0);
            chk("abort_done", done, 0);
            chk("abort_sum", checksum, sum);
            step();
            chk("abort_no_done", done, 0);
        end else begin
            if (readyPct >= 100) chk("done_cycle", cyc, 2 * n);
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
            chk("done_valid", out_valid, 0);
            chk("done_sum", checksum, sum);
            step();
            chk("done_clear", done, 0);
            chk("sum_hold", checksum, sum);
        end
    endtask

    vec_t vecs[$];

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        first_addr = '0; last_addr = '0;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[1] = 32'h11111111; regs[2] = 32'h22222222; regs[3] = 32'h33333333;

        vecs.push_back('{5'd1,  5'd3,  100, -1, 1'b0, 1'b1, 32'h66666666});
        vecs.push_back('{5'd0,  5'd31, 100,  2, 1'b0, 1'b1, 32'h33333333});
        vecs.push_back('{5'd5,  5'd9,  100, -1, 1'b1, 1'b0, 32'h0});
        vecs.push_back('{5'd7,  5'd6,  70,  -1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{5'd0,  5'd31, 40,  -1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{5'd10, 5'd10, 50,  -1, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{5'd20, 5'd4,  60,  -1, 1'b1, 1'b0, 32'h0});

        step(); step();
        chk("rst_state_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_checksum", checksum, 0);
        reset = 1'b1;
        step();

        // start is blocked by abort while idle
        start = 1'b1; abort = 1'b1; first_addr = 5'd1; last_addr = 5'd2;
        step();
        start = 1'b0; abort = 1'b0;
        chk("start_blocked", busy, 0);
        step();

        foreach (vecs[i]) begin
            runDump(vecs[i].f, vecs[i].l, vecs[i].readyPct, vecs[i].abortAddr, vecs[i].noisy);
            if (vecs[i].hasSum) chk("table_sum", checksum, vecs[i].expSum);
            step();
        end

        regs[30] = 32'd5; regs[31] = 32'd6; regs[1] = 32'd7;
        runDump(5'd30, 5'd1, 100, -1, 1'b0);
        chk("wrap_sum", checksum, 32'd18);
        step();

        regs[4] = 32'hDEADBEEF;
        start = 1'b1; first_addr = 5'd4; last_addr = 5'd4; out_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 32'hDEADBEEF);
            chk("bp_last", out_last, 1);
            step();
        end
        out_ready = 1'b1;
        chk("bp_valid_final", out_valid, 1);
        step();
        out_ready = 1'b0;
        chk("bp_done", done, 1);
        chk("bp_sum", checksum, 32'hDEADBEEF);
        step();
        chk("bp_done_clear", done, 0);

        start = 1'b1; first_addr = 5'd0; last_addr = 5'd31; out_ready = 1'b0;
        step();
        start = 1'b0;
        step();
        chk("pre_reset_valid", out_valid, 1);
        reset = 1'b0;
        step();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_rd_addr", rd_addr, 0);
        chk("mid_rst_addr", out_addr, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_last", out_last, 0);
        chk("mid_rst_sum", checksum, 0);
        reset = 1'b1;
        step();
        runDump(5'd0, 5'd0, 100, -1, 1'b0);
        chk("zero_sum", checksum, 0);
        step();

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            runDump(5'($urandom), 5'($urandom), int'($urandom_range(30, 100)), -1, 1'($urandom_range(1)));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
